seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl_if.sv | 29 ++
 rtl/seq_det_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_det_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Handshake bundle for seq_det_ctrl: configuration, run control, serial input and status.
// The master drives configuration and stimulus; the slave (the detector) drives status.
interface seq_det_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_we;
  logic [3:0]       cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
  logic             start;
  logic             stop;
  logic             in_valid;
  logic             in;
  logic             det;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] det_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, in_valid, in,
    input  det, busy, done, aborted, det_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, in_valid, in,
    output det, busy, done, aborted, det_count
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: counts matches of a 2..4 bit pattern over a window of
// accepted bits, with overlapping or non-overlapping matching and an abortable run.
module seq_det_ctrl #(
  parameter int WINDOW = 50,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  seq_det_ctrl_if.slave bus
);

  localparam int BIT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       pat_q;
  logic [2:0]       len_q;
  logic             ovl_q;
  logic [3:0]       hist_q;
  logic [2:0]       fill_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] det_count_q;
  logic             det_q;
  logic             done_q;
  logic             busy_q;
  logic             aborted_q;

  logic [3:0]       hist_d;
  logic [2:0]       fill_d;
  logic             pat_eq_d;
  logic             match_d;
  logic             last_bit_d;

  // Lengths outside 2..4 are folded onto the nearest supported length.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    logic [2:0] res;
    if (len < 3'd2) begin
      res = 3'd2;
    end else if (len > 3'd4) begin
      res = 3'd4;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Candidate history/fill for the bit currently offered, and the match it would produce.
  always_comb begin
    hist_d     = {hist_q[2:0], bus.in};
    fill_d     = (fill_q == 3'd4) ? 3'd4 : (fill_q + 3'd1);
    pat_eq_d   = 1'b0;
    case (len_q)
      3'd2:    pat_eq_d = (hist_d[1:0] == pat_q[1:0]);
      3'd3:    pat_eq_d = (hist_d[2:0] == pat_q[2:0]);
      3'd4:    pat_eq_d = (hist_d == pat_q);
      default: pat_eq_d = 1'b0;
    endcase
    match_d    = (fill_d >= len_q) && pat_eq_d;
    last_bit_d = (bit_cnt_q == BIT_W'(WINDOW - 1));
  end

  // Run-control FSM with all status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= 4'b0101;
      len_q       <= 3'd3;
      ovl_q       <= 1'b0;
      hist_q      <= 4'd0;
      fill_q      <= 3'd0;
      bit_cnt_q   <= '0;
      det_count_q <= '0;
      det_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          det_q  <= 1'b0;
          done_q <= 1'b0;
          if (bus.cfg_we) begin
            pat_q <= bus.cfg_pattern;
            len_q <= clamp_len(bus.cfg_len);
            ovl_q <= bus.cfg_overlap;
          end
          if (bus.start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            hist_q      <= 4'd0;
            fill_q      <= 3'd0;
            bit_cnt_q   <= '0;
            det_count_q <= '0;
            aborted_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          det_q <= 1'b0;
          if (bus.in_valid) begin
            hist_q    <= hist_d;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            fill_q    <= (match_d && !ovl_q) ? 3'd0 : fill_d;
            if (match_d) begin
              det_q <= 1'b1;
              if (det_count_q != {CNT_W{1'b1}}) begin
                det_count_q <= det_count_q + CNT_W'(1);
              end
            end
          end
          // A completed window wins over a simultaneous stop, so the run is not marked aborted.
          if (bus.in_valid && last_bit_d) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (bus.stop) begin
            state_q   <= ST_FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          det_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          det_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.det       = det_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.det_count = det_count_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a reference model pushes expected status per cycle,
// two DUTs (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.CNT_W(8)) bus  ();
  seq_det_ctrl_if #(.CNT_W(2)) bus2 ();

  assign bus2.cfg_we      = bus.cfg_we;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.start       = bus.start;
  assign bus2.stop        = bus.stop;
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.in          = bus.in;

  seq_det_ctrl #(.WINDOW(50), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_det_ctrl #(.WINDOW(50), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic det;
    logic busy;
    logic done;
    logic aborted;
    int   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;

  // Reference model state
  int         m_st;
  logic [3:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic [3:0] m_hist;
  int         m_fill;
  int         m_nb;
  int         m_cnt;
  logic       m_ab;
  logic       m_det;
  logic       m_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic cw, input logic [3:0] p, input logic [2:0] l,
                            input logic ov, input logic st, input logic sp, input logic iv, input logic b);
    logic [3:0] mask;
    logic       hit;
    if (r) begin
      m_st = 0; m_pat = 4'b0101; m_len = 3; m_ovl = 1'b0;
      m_hist = 4'd0; m_fill = 0; m_nb = 0; m_cnt = 0;
      m_ab = 1'b0; m_det = 1'b0; m_done = 1'b0;
    end else begin
      case (m_st)
        0: begin
          m_det = 1'b0; m_done = 1'b0;
          if (cw) begin
            m_pat = p;
            m_len = (int'(l) < 2) ? 2 : ((int'(l) > 4) ? 4 : int'(l));
            m_ovl = ov;
          end
          if (st) begin
            m_st = 1; m_hist = 4'd0; m_fill = 0; m_nb = 0; m_cnt = 0; m_ab = 1'b0;
          end
        end
        1: begin
          m_det = 1'b0;
          if (iv) begin
            m_hist = {m_hist[2:0], b};
            m_nb++;
            if (m_fill < 4) m_fill++;
            mask = 4'((1 << m_len) - 1);
            hit = (m_fill >= m_len) && (((m_hist ^ m_pat) & mask) == 4'd0);
            if (hit) begin
              m_det = 1'b1;
              m_cnt++;
              if (!m_ovl) m_fill = 0;
            end
          end
          if (iv && m_nb == 50) begin
            m_st = 2; m_done = 1'b1;
          end else if (sp) begin
            m_st = 2; m_done = 1'b1; m_ab = 1'b1;
          end
        end
        default: begin
          m_st = 0; m_done = 1'b0; m_det = 1'b0;
        end
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic cw, input logic [3:0] p, input logic [2:0] l,
                       input logic ov, input logic st, input logic sp, input logic iv, input logic b);
    exp_t e;
    int   c8;
    int   c2;
    rst = r;
    bus.cfg_we = cw; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = ov;
    bus.start = st; bus.stop = sp; bus.in_valid = iv; bus.in = b;
    model_step(r, cw, p, l, ov, st, sp, iv, b);
    e.det = m_det; e.busy = (m_st == 1); e.done = m_done; e.aborted = m_ab; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e  = sb_q.pop_front();
    c8 = (e.cnt > 255) ? 255 : e.cnt;
    c2 = (e.cnt > 3) ? 3 : e.cnt;
    check_val("det",       32'(bus.det),        32'(e.det));
    check_val("busy",      32'(bus.busy),       32'(e.busy));
    check_val("done",      32'(bus.done),       32'(e.done));
    check_val("aborted",   32'(bus.aborted),    32'(e.aborted));
    check_val("det_count", 32'(bus.det_count),  32'(c8));
    check_val("cnt_sat2",  32'(bus2.det_count), 32'(c2));
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic ov);
    cycle(1'b0, 1'b1, p, l, ov, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b);
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic halt();
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nop();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_pattern = 4'd0; bus.cfg_len = 3'd0; bus.cfg_overlap = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0; bus.in = 1'b0;

    cycle(1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_cnt", 32'(bus.det_count), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Default 101 non-overlapping
    go();
    feed(16'b10101, 5);
    check_val("default_cnt", 32'(bus.det_count), 32'd1);
    halt();

    // Overlapping 101
    cfg(4'b0101, 3'd3, 1'b1);
    go();
    feed(16'b10101, 5);
    check_val("overlap_cnt", 32'(bus.det_count), 32'd2);
    halt();

    // 1111 overlapping, counter saturation on the narrow instance
    cfg(4'b1111, 3'd4, 1'b1);
    go();
    feed(16'hFF, 8);
    check_val("ones_cnt8", 32'(bus.det_count), 32'd5);
    check_val("ones_cnt2", 32'(bus2.det_count), 32'd3);
    halt();

    // Length clamping: 0 -> 2 and 7 -> 4
    cfg(4'b0001, 3'd0, 1'b0);
    go();
    feed(16'b0101, 4);
    check_val("clamp_lo_cnt", 32'(bus.det_count), 32'd2);
    halt();
    cfg(4'b1010, 3'd7, 1'b0);
    go();
    feed(16'b01010, 5);
    check_val("clamp_hi_cnt", 32'(bus.det_count), 32'd1);
    halt();

    // Stop after 10 bits with an ignored mid-run configuration write
    cfg(4'b0101, 3'd3, 1'b0);
    go();
    feed(16'b10, 2);
    cycle(1'b0, 1'b1, 4'b0110, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b1011010, 7);
    check_val("stop10_cnt", 32'(bus.det_count), 32'd3);
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("stop_done", 32'(bus.done), 32'd1);
    check_val("stop_busy", 32'(bus.busy), 32'd0);
    nop();
    check_val("stop_aborted", 32'(bus.aborted), 32'd1);
    check_val("stop_done_low", 32'(bus.done), 32'd0);

    // Bit accepted together with stop still matches
    go();
    feed(16'b10, 2);
    cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("stop_match_det", 32'(bus.det), 32'd1);
    nop();

    // Full window with gaps; stop coincides with the last bit
    go();
    for (int n = 0; n < 50; ) begin
      if ($urandom_range(0, 2) == 0) begin
        cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, (n == 49), 1'b1, 1'($urandom_range(0, 1)));
        n++;
      end
    end
    check_val("win_done", 32'(bus.done), 32'd1);
    check_val("win_busy", 32'(bus.busy), 32'd0);
    check_val("win_aborted", 32'(bus.aborted), 32'd0);
    cycle(1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("win_done_low", 32'(bus.done), 32'd0);
    nop();

    // Reset mid-run after one detection, with every other input asserted
    cfg(4'b0011, 3'd2, 1'b1);
    go();
    feed(16'b011, 3);
    check_val("pre_rst_cnt", 32'(bus.det_count), 32'd1);
    cycle(1'b1, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_val("rst_cnt", 32'(bus.det_count), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    go();
    feed(16'b10101, 5);
    check_val("post_rst_cnt", 32'(bus.det_count), 32'd1);
    halt();

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
